// File: rtl/eld_disp_pkg.sv
// Shared constants for the seven-segment BCD display counter: digit count,
// active-low segment patterns {g,f,e,d,c,b,a} and the nibble decoder.
package eld_disp_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the up/down counter. carry_out flags the digit that
// rolls over on the next step in the current direction (9 up, 0 down).
module bcd_digit (
  input  logic       inp_clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       step,
  input  logic       up,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (step) begin
      if (up) digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
      else    digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  always_ff @(posedge inp_clk or posedge rst) begin
    if (rst) digit_q <= 4'd0;
    else     digit_q <= digit_d;
  end

  assign digit     = digit_q;
  assign carry_out = up ? (digit_q == 4'd9) : (digit_q == 4'd0);

endmodule

// File: rtl/bcd_display_counter.sv
// 4-digit BCD up/down counter advanced by rising edges of a synchronised slow
// clock, with a multiplexed common-anode seven-segment display scanner.
module bcd_display_counter #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        inp_clk,
  input  logic        rst,
  input  logic        slow_clk,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  output logic [15:0] count,
  output logic        wrap,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  import eld_disp_pkg::*;

  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  logic              s1_q, s2_q, s3_q;
  logic              tick;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] carry;
  logic [3:0]        digit [DIGITS];
  logic [15:0]       count_w;
  logic              wrap_q, wrap_d;
  logic [REF_W-1:0]  ref_q, ref_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  always_ff @(posedge inp_clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= slow_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .inp_clk   (inp_clk),
      .rst       (rst),
      .clr       (clr),
      .step      (step[k]),
      .up        (up),
      .digit     (digit[k]),
      .carry_out (carry[k])
    );
  end

  // Ripple the enable up through the digits; surviving past the top means wrap.
  always_comb begin
    logic run;
    run     = tick & en;
    step    = '0;
    count_w = '0;
    for (int k = 0; k < DIGITS; k++) begin
      step[k]          = run;
      run              = run & carry[k];
      count_w[4*k +: 4] = digit[k];
    end
    wrap_d = run & ~clr;
  end

  always_comb begin
    ref_d = ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end
    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg_decode(count_w[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge inp_clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
      ref_q  <= '0;
      idx_q  <= 2'd0;
      an_q   <= 4'b1110;
      seg_q  <= SEG_0;
    end else begin
      wrap_q <= wrap_d;
      ref_q  <= ref_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign count = count_w;
  assign wrap  = wrap_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed bench for bcd_display_counter with a short refresh period.
module tb_bcd_display_counter;

  logic        inp_clk = 1'b0;
  logic        rst;
  logic        slow_clk;
  logic        en;
  logic        up;
  logic        clr;
  logic [15:0] count;
  logic        wrap;
  logic [6:0]  seg;
  logic [3:0]  an;

  int tests_run    = 0;
  int tests_failed = 0;

  bcd_display_counter #(.REFRESH_DIV(4)) dut (
    .inp_clk  (inp_clk),
    .rst      (rst),
    .slow_clk (slow_clk),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .count    (count),
    .wrap     (wrap),
    .seg      (seg),
    .an       (an)
  );

  always #5 inp_clk = ~inp_clk;

  task automatic step_clk();
    @(posedge inp_clk);
    #1;
  endtask

  task automatic tick_once();
    slow_clk = 1'b1;
    repeat (3) step_clk();
    slow_clk = 1'b0;
    repeat (3) step_clk();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step_clk();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_count got=%h want=0000", count);
    end
    tests_run++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got an=%b seg=%b wrap=%b want an=1110 seg=1000000 wrap=0",
               an, seg, wrap);
    end
  endtask

  task automatic test_latency();
    logic [15:0] exp_lat [3];
    exp_lat[0] = 16'h0000;
    exp_lat[1] = 16'h0000;
    exp_lat[2] = 16'h0001;
    en = 1'b1;
    up = 1'b1;
    slow_clk = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step_clk();
      tests_run++;
      if (count !== exp_lat[e]) begin
        tests_failed++;
        $display("FAIL latency_edge%0d got=%h want=%h", e + 1, count, exp_lat[e]);
      end
    end
    slow_clk = 1'b0;
    repeat (3) step_clk();
    tests_run++;
    if (count !== 16'h0001) begin
      tests_failed++;
      $display("FAIL falling_edge_no_tick got=%h want=0001", count);
    end
    repeat (7) tick_once();
    tests_run++;
    if (count !== 16'h0008) begin
      tests_failed++;
      $display("FAIL eight_pulses got=%h want=0008", count);
    end
  endtask

  task automatic test_carry();
    do_clr();
    up = 1'b1;
    repeat (999) tick_once();
    tests_run++;
    if (count !== 16'h0999) begin
      tests_failed++;
      $display("FAIL preload_0999 got=%h want=0999", count);
    end
    tick_once();
    tests_run++;
    if (count !== 16'h1000) begin
      tests_failed++;
      $display("FAIL carry_1000 got=%h want=1000", count);
    end
  endtask

  task automatic test_wrap_pulse(input logic dir, input logic [15:0] exp_cnt);
    up = dir;
    slow_clk = 1'b1;
    step_clk();
    step_clk();
    tests_run++;
    if (wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_early dir=%0d got=%b want=0", dir, wrap);
    end
    step_clk();
    tests_run++;
    if (count !== exp_cnt || wrap !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_value dir=%0d got count=%h wrap=%b want count=%h wrap=1",
               dir, count, wrap, exp_cnt);
    end
    step_clk();
    tests_run++;
    if (wrap !== 1'b0 || count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL wrap_one_cycle dir=%0d got count=%h wrap=%b want count=%h wrap=0",
               dir, count, wrap, exp_cnt);
    end
    slow_clk = 1'b0;
    repeat (3) step_clk();
  endtask

  task automatic test_borrow();
    up = 1'b0;
    tick_once();
    tests_run++;
    if (count !== 16'h0999) begin
      tests_failed++;
      $display("FAIL borrow_0999 got=%h want=0999", count);
    end
    do_clr();
    test_wrap_pulse(1'b0, 16'h9999);
    test_wrap_pulse(1'b1, 16'h0000);
  endtask

  task automatic test_priority();
    do_clr();
    up = 1'b1;
    en = 1'b1;
    repeat (5) tick_once();
    en = 1'b0;
    tick_once();
    tests_run++;
    if (count !== 16'h0005) begin
      tests_failed++;
      $display("FAIL en_low_hold got=%h want=0005", count);
    end
    en = 1'b1;
    slow_clk = 1'b1;
    step_clk();
    step_clk();
    clr = 1'b1;
    step_clk();
    clr = 1'b0;
    tests_run++;
    if (count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL clr_vs_tick got=%h want=0000", count);
    end
    slow_clk = 1'b0;
    repeat (3) step_clk();
    tests_run++;
    if (count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL tick_discarded got=%h want=0000", count);
    end
    tick_once();
    tick_once();
    up = 1'b0;
    tick_once();
    tests_run++;
    if (count !== 16'h0001) begin
      tests_failed++;
      $display("FAIL dir_toggle_down got=%h want=0001", count);
    end
    up = 1'b1;
    tick_once();
    tests_run++;
    if (count !== 16'h0002) begin
      tests_failed++;
      $display("FAIL dir_toggle_up got=%h want=0002", count);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic [3:0] prev_an;
    int         waited;
    exp_an[0]  = 4'b1110; exp_seg[0] = 7'b0011001;
    exp_an[1]  = 4'b1101; exp_seg[1] = 7'b0110000;
    exp_an[2]  = 4'b1011; exp_seg[2] = 7'b0100100;
    exp_an[3]  = 4'b0111; exp_seg[3] = 7'b1111001;
    do_clr();
    up = 1'b1;
    en = 1'b1;
    repeat (1234) tick_once();
    tests_run++;
    if (count !== 16'h1234) begin
      tests_failed++;
      $display("FAIL preload_1234 got=%h want=1234", count);
    end
    prev_an = an;
    waited  = 0;
    step_clk();
    while (!(an === 4'b1110 && prev_an === 4'b0111) && waited < 40) begin
      prev_an = an;
      waited++;
      step_clk();
    end
    tests_run++;
    if (waited >= 40) begin
      tests_failed++;
      $display("FAIL scan_sync got an=%b want frame start 0111->1110 within 40 cycles", an);
    end
    for (int j = 0; j <= 16; j++) begin
      tests_run++;
      if (an !== exp_an[(j / 4) % 4] || seg !== exp_seg[(j / 4) % 4]) begin
        tests_failed++;
        $display("FAIL scan_cycle%0d got an=%b seg=%b want an=%b seg=%b",
                 j, an, seg, exp_an[(j / 4) % 4], exp_seg[(j / 4) % 4]);
      end
      step_clk();
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    #2;
    tests_run++;
    if (count !== 16'h0000 || an !== 4'b1110 || seg !== 7'b1000000 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset got count=%h an=%b seg=%b wrap=%b want 0000/1110/1000000/0",
               count, an, seg, wrap);
    end
    step_clk();
    rst = 1'b0;
    step_clk();
  endtask

  initial begin
    rst      = 1'b1;
    slow_clk = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    clr      = 1'b0;
    repeat (2) step_clk();
    rst = 1'b0;
    step_clk();
    test_reset();
    test_latency();
    test_carry();
    test_borrow();
    test_priority();
    test_scan();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
